// File: rtl/min2_pkg.sv
// Shared types and defaults for the two-smallest-candidate tracker.
package min2_pkg;
  localparam int DW_DEF        = 15;
  localparam int GROUP_LEN_DEF = 8;
  localparam int NUM_ROWS_DEF  = 5;

  // Sliced down to DW by users; an all-ones minimum loses to any real candidate.
  localparam logic [63:0] MIN_INIT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/min2_update.sv
// Combinational compare-update of the running smallest/second-smallest pair.
module min2_update #(
  parameter int DW = 15
) (
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] min1,
  input  logic [DW-1:0] min2,
  output logic [DW-1:0] min1_nxt,
  output logic [DW-1:0] min2_nxt
);
  // Strict compares: a duplicate of min1 falls through to the min2 branch.
  always_comb begin
    min1_nxt = min1;
    min2_nxt = min2;
    if (d < min1) begin
      min2_nxt = min1;
      min1_nxt = d;
    end else if (d < min2) begin
      min2_nxt = d;
    end
  end
endmodule

// File: rtl/min2_tracker.sv
// Tracks the two smallest candidates per row, writing each row's pair
// downstream after GROUP_LEN accepted candidates, for NUM_ROWS rows per run.
module min2_tracker
  import min2_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int GROUP_LEN = GROUP_LEN_DEF,
  parameter int NUM_ROWS  = NUM_ROWS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [2:0]    wr_addr,
  output logic [DW-1:0] mini1,
  output logic [DW-1:0] mini2,
  output logic          busy,
  output logic          done
);
  localparam logic [DW-1:0] INIT     = MIN_INIT[DW-1:0];
  localparam logic [7:0]    CNT_LAST = 8'(GROUP_LEN - 1);
  localparam logic [2:0]    ROW_LAST = 3'(NUM_ROWS - 1);

  state_t        state_q, state_d;
  logic [2:0]    row_q;
  logic [7:0]    cnt_q;
  logic [DW-1:0] min1_q, min2_q;
  logic [DW-1:0] min1_nxt, min2_nxt;
  logic          acc, last_cand, last_row;

  assign acc       = in_valid && (state_q == SCAN);
  assign last_cand = (cnt_q == CNT_LAST);
  assign last_row  = (row_q == ROW_LAST);

  min2_update #(.DW(DW)) u_upd (
    .d        (in_data),
    .min1     (min1_q),
    .min2     (min2_q),
    .min1_nxt (min1_nxt),
    .min2_nxt (min2_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (acc && last_cand) state_d = COMMIT;
      COMMIT:  state_d = last_row ? FINISH : SCAN;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      cnt_q  <= '0;
      min1_q <= INIT;
      min2_q <= INIT;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          row_q  <= '0;
          cnt_q  <= '0;
          min1_q <= INIT;
          min2_q <= INIT;
        end
        SCAN: if (acc) begin
          cnt_q  <= cnt_q + 8'd1;
          min1_q <= min1_nxt;
          min2_q <= min2_nxt;
        end
        // The pair is held through COMMIT so the write sees final values.
        COMMIT: if (!last_row) begin
          row_q  <= row_q + 3'd1;
          cnt_q  <= '0;
          min1_q <= INIT;
          min2_q <= INIT;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state_q == SCAN);
  assign wr_en    = (state_q == COMMIT);
  assign wr_addr  = (state_q == COMMIT) ? row_q : 3'd0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign mini1    = min1_q;
  assign mini2    = min2_q;
endmodule

// File: tb/tb_min2_tracker.sv
// Scoreboard bench for min2_tracker: expected row pairs are queued as rows are
// driven and popped when the write strobe appears.
module tb_min2_tracker;
  import min2_pkg::*;

  localparam int DW = 15;
  localparam int GL = 8;
  localparam int NR = 5;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, wr_en, busy, done;
  logic [2:0]    wr_addr;
  logic [DW-1:0] mini1, mini2;

  min2_tracker #(.DW(DW), .GROUP_LEN(GL), .NUM_ROWS(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .mini1    (mini1),
    .mini2    (mini2),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    addr;
    logic [DW-1:0] m1;
    logic [DW-1:0] m2;
  } exp_t;

  exp_t          sbq[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [DW-1:0] rows [NR][GL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Smallest value, then smallest of the remaining entries (duplicates kept).
  function automatic exp_t model(input int r);
    exp_t e;
    int   idx, best;
    idx = 0;
    for (int j = 1; j < GL; j++) if (rows[r][j] < rows[r][idx]) idx = j;
    best = -1;
    for (int j = 0; j < GL; j++)
      if (j != idx && (best < 0 || rows[r][j] < rows[r][best])) best = j;
    e.addr = 3'(r);
    e.m1   = rows[r][idx];
    e.m2   = rows[r][best];
    return e;
  endfunction

  task automatic drive_row(input int r, input int n, input bit rnd, input bit poke_start);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int tries;
      tries = 0;
      do begin
        in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = in_valid ? rows[r][i] : DW'($urandom);
        start    = poke_start && (i == 3) && (tries == 0);
        acc      = in_valid && in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        tries++;
      end while (!acc && tries < 200);
      if (!acc) chk("drv_stall", 32'(acc), 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input bit rnd);
    int k;
    start_run();
    for (int r = 0; r < NR; r++) sbq.push_back(model(r));
    for (int r = 0; r < NR; r++) drive_row(r, GL, rnd, rnd && r == 1);
    k = 0;
    while (busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("run_end_busy", 32'(busy), 0);
    chk("sb_drained", sbq.size(), 0);
  endtask

  // Monitor: write latency, popped pair contents, done placement, busy drop.
  int acc_cnt   = 0;
  bit exp_wr    = 0;
  bit exp_done  = 0;
  bit prev_done = 0;
  always @(negedge clk) begin
    if (reset) begin
      acc_cnt = 0; exp_wr = 0; exp_done = 0; prev_done = 0;
    end else begin
      if (wr_en || exp_wr) chk("wr_latency", 32'(wr_en), 32'(exp_wr));
      if (wr_en) begin
        if (sbq.size() == 0) chk("wr_unexpected", sbq.size(), 1);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("mini1", 32'(mini1), 32'(e.m1));
          chk("mini2", 32'(mini2), 32'(e.m2));
        end
      end
      if (done || exp_done) chk("done", 32'(done), 32'(exp_done));
      if (prev_done) chk("busy_after_done", 32'(busy), 0);
      prev_done = done;
      exp_done  = wr_en && (wr_addr == 3'(NR - 1));
      exp_wr    = in_valid && in_ready && (acc_cnt == GL - 1);
      if (in_valid && in_ready) acc_cnt = (acc_cnt == GL - 1) ? 0 : acc_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] r0 [GL];
    logic [DW-1:0] r2 [GL];
    r0 = '{15'd9, 15'd3, 15'd7, 15'd3, 15'd12, 15'd1, 15'd20, 15'd5};
    r2 = '{15'd4, 15'd4, 15'd9, 15'd9, 15'd9, 15'd9, 15'd9, 15'd9};
    for (int j = 0; j < GL; j++) begin
      rows[0][j] = r0[j];
      rows[1][j] = 15'h7fff;
      rows[2][j] = r2[j];
      rows[3][j] = DW'($urandom_range(0, 32767));
      rows[4][j] = DW'($urandom_range(0, 63));
    end

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wr_en",    32'(wr_en), 0);
    chk("rst_wr_addr",  32'(wr_addr), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_mini1",    32'(mini1), 32'h7fff);
    chk("rst_mini2",    32'(mini2), 32'h7fff);
    reset = 1'b0;
    @(posedge clk); #1;

    run(1'b0);   // continuous data
    run(1'b1);   // random stalls plus a stray start mid-row

    // Abort row 2 after five acceptances; its pair must never be written.
    start_run();
    sbq.push_back(model(0));
    sbq.push_back(model(1));
    drive_row(0, GL, 1'b0, 1'b0);
    drive_row(1, GL, 1'b0, 1'b0);
    drive_row(2, 5, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_busy",     32'(busy), 0);
    chk("arst_wr_en",    32'(wr_en), 0);
    chk("arst_wr_addr",  32'(wr_addr), 0);
    chk("arst_done",     32'(done), 0);
    chk("arst_sb",       sbq.size(), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 0);

    run(1'b0);   // fresh run after reset starts at wr_addr 0

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
